// File: rtl/mul_final_add.sv
// Final carry-propagate adder of the multiplier: folds the compressor S/C rows
// into a 64-bit product and buffers results in a 3-entry in-order queue.
module mul_final_add (
    input  logic        mul_clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_hi,
    output logic        issue_ready,
    input  logic        flush,
    input  logic [63:0] wal_s,
    input  logic [63:0] wal_c,
    input  logic        wal_cin0,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [63:0] res_full
);

    localparam int unsigned DEPTH = 3;

    function automatic logic [1:0] f_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic        r_a_v;
    logic        r_a_hi;
    logic [63:0] r_q_sum [DEPTH];
    logic        r_q_hi  [DEPTH];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [1:0]  r_cnt;
    logic [31:0] r_res_data;
    logic [63:0] r_res_full;

    logic [63:0] w_sum;
    logic [2:0]  w_occ;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_wptr_n;
    logic [1:0]  w_rptr_n;
    logic [1:0]  w_cnt_n;
    logic [63:0] w_head_sum;
    logic        w_head_hi;

    always_comb begin
        w_sum       = wal_s + {wal_c[62:0], wal_cin0};
        w_occ       = {1'b0, r_cnt} + {2'b00, r_a_v};
        issue_ready = (w_occ <= 3'd2) && !flush && !reset;
        w_accept    = issue_valid && issue_ready;
        w_push      = r_a_v;
        w_pop       = res_valid && res_ready;
        w_wptr_n    = w_push ? f_inc(r_wptr) : r_wptr;
        w_rptr_n    = w_pop ? f_inc(r_rptr) : r_rptr;
        w_cnt_n     = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        // the next head may be the entry being written on this very edge
        if (w_push && (w_rptr_n == r_wptr)) begin
            w_head_sum = w_sum;
            w_head_hi  = r_a_hi;
        end else begin
            w_head_sum = r_q_sum[w_rptr_n];
            w_head_hi  = r_q_hi[w_rptr_n];
        end
    end

    always_ff @(posedge mul_clk) begin
        if (reset) begin
            r_a_v      <= 1'b0;
            r_a_hi     <= 1'b0;
            r_wptr     <= 2'd0;
            r_rptr     <= 2'd0;
            r_cnt      <= 2'd0;
            r_res_data <= 32'd0;
            r_res_full <= 64'd0;
        end else if (flush) begin
            r_a_v  <= 1'b0;
            r_wptr <= 2'd0;
            r_rptr <= 2'd0;
            r_cnt  <= 2'd0;
        end else begin
            r_a_v <= w_accept;
            if (w_accept) begin
                r_a_hi <= issue_hi;
            end
            if (w_push) begin
                r_q_sum[r_wptr] <= w_sum;
                r_q_hi[r_wptr]  <= r_a_hi;
            end
            r_wptr <= w_wptr_n;
            r_rptr <= w_rptr_n;
            r_cnt  <= w_cnt_n;
            if (w_cnt_n != 2'd0) begin
                r_res_full <= w_head_sum;
                r_res_data <= w_head_hi ? w_head_sum[63:32] : w_head_sum[31:0];
            end
        end
    end

    assign res_valid = (r_cnt != 2'd0);
    assign res_data  = r_res_data;
    assign res_full  = r_res_full;

endmodule

// File: tb/tb_mul_final_add.sv
// Scoreboard bench for mul_final_add: expectations queued at issue acceptance,
// compared against each popped head result.
module tb_mul_final_add;

    typedef struct {
        logic [63:0] full;
        logic [31:0] data;
    } exp_t;

    logic        mul_clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_hi = 1'b0;
    logic        issue_ready;
    logic        flush = 1'b0;
    logic [63:0] wal_s = 64'd0;
    logic [63:0] wal_c = 64'd0;
    logic        wal_cin0 = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [63:0] res_full;

    logic [63:0] nxt_s = 64'd0;
    logic [63:0] nxt_c = 64'd0;
    logic        nxt_cin = 1'b0;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    mul_final_add dut (
        .mul_clk(mul_clk), .reset(reset),
        .issue_valid(issue_valid), .issue_hi(issue_hi),
        .issue_ready(issue_ready), .flush(flush),
        .wal_s(wal_s), .wal_c(wal_c), .wal_cin0(wal_cin0),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_full(res_full)
    );

    always #5 mul_clk = ~mul_clk;

    // Operand driver: an accepted issue gets its S/C rows one cycle later;
    // otherwise the rows carry noise that must be ignored.
    always @(posedge mul_clk) begin
        logic        acc;
        logic        lhi;
        logic        lcin;
        logic [63:0] ls;
        logic [63:0] lc;
        exp_t        e;
        acc  = issue_valid && issue_ready;
        lhi  = issue_hi;
        ls   = nxt_s;
        lc   = nxt_c;
        lcin = nxt_cin;
        if (reset || flush) begin
            sb.delete();
        end else if (acc) begin
            e.full = ls + {lc[62:0], lcin};
            e.data = lhi ? e.full[63:32] : e.full[31:0];
            sb.push_back(e);
        end
        #1;
        if (acc && !reset && !flush) begin
            wal_s    = ls;
            wal_c    = lc;
            wal_cin0 = lcin;
        end else begin
            wal_s    = {$urandom, $urandom};
            wal_c    = {$urandom, $urandom};
            wal_cin0 = 1'($urandom);
        end
    end

    // Result monitor and full-queue push check
    always @(negedge mul_clk) begin
        exp_t e;
        if (!reset && !flush && dut.r_a_v && dut.r_cnt == 2'd3) begin
            n_err++;
            $display("FAIL push_into_full cnt=%0d required<3", dut.r_cnt);
        end
        if (!reset && res_valid && res_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result full=%h required=none", res_full);
            end else begin
                e = sb.pop_front();
                if (res_full !== e.full || res_data !== e.data) begin
                    n_err++;
                    $display("FAIL result full=%h data=%h required full=%h data=%h",
                             res_full, res_data, e.full, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge mul_clk);
        #1;
    endtask

    task automatic do_issue(input logic [63:0] s, input logic [63:0] c,
                            input logic cin, input logic hi);
        int k;
        k = 0;
        issue_valid = 1'b1;
        issue_hi    = hi;
        nxt_s       = s;
        nxt_c       = c;
        nxt_cin     = cin;
        while (!issue_ready && k < 20) begin
            tick();
            k++;
        end
        n_vec++;
        if (!issue_ready) begin
            n_err++;
            $display("FAIL issue_timeout issue_ready=%b required=1", issue_ready);
        end
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++;
        if (issue_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_ready got=%b required=0", issue_ready);
        end
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_valid got=%b required=0", res_valid);
        end
        n_vec++;
        if (res_full !== 64'd0 || res_data !== 32'd0) begin
            n_err++; $display("FAIL rst_data full=%h data=%h required=0", res_full, res_data);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (issue_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_release_ready got=%b required=1", issue_ready);
        end
    endtask

    task automatic test_basic();
        res_ready = 1'b0;
        do_issue(64'h5, 64'h3, 1'b1, 1'b0);
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_early got=%b required=0", res_valid);
        end
        tick();
        n_vec++;
        if (res_valid !== 1'b1 || res_full !== 64'hC || res_data !== 32'hC) begin
            n_err++;
            $display("FAIL basic v=%b full=%h data=%h required 1/C/C", res_valid, res_full, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_drain got=%b required=0", res_valid);
        end
    endtask

    task automatic test_wrap();
        do_issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
        tick();
        n_vec++;
        if (res_valid !== 1'b1 || res_full !== 64'd0 || res_data !== 32'd0) begin
            n_err++;
            $display("FAIL wrap v=%b full=%h data=%h required 1/0/0", res_valid, res_full, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_hi_select();
        do_issue(64'h0000_0001_0000_0000, 64'd0, 1'b0, 1'b1);
        do_issue(64'h0000_0001_0000_0000, 64'd0, 1'b0, 1'b0);
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== 32'h1) begin
            n_err++; $display("FAIL hi_sel_hi v=%b data=%h required 1/1", res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== 32'h0 || res_full !== 64'h0000_0001_0000_0000) begin
            n_err++;
            $display("FAIL hi_sel_lo v=%b data=%h full=%h required 1/0/100000000",
                     res_valid, res_data, res_full);
        end
        tick();
        res_ready = 1'b0;
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_err++; $display("FAIL hi_sel_drain got=%b required=0", res_valid);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        res_ready   = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue_hi = 1'($urandom);
            nxt_s    = {$urandom, $urandom};
            nxt_c    = {$urandom, $urandom};
            nxt_cin  = 1'($urandom);
            if (issue_ready) acc++;
            tick();
        end
        n_vec++;
        if (acc != 3) begin
            n_err++; $display("FAIL bp_accepts got=%0d required=3", acc);
        end
        n_vec++;
        if (issue_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_ready got=%b required=0", issue_ready);
        end
        issue_valid = 1'b0;
        res_ready   = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        res_ready = 1'b0;
        n_vec++;
        if (res_valid !== 1'b0 || issue_ready !== 1'b1 || sb.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain v=%b rdy=%b left=%0d required 0/1/0",
                     res_valid, issue_ready, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        acc = 0;
        res_ready   = 1'b1;
        issue_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            issue_hi = 1'($urandom);
            nxt_s    = {$urandom, $urandom};
            nxt_c    = {$urandom, $urandom};
            nxt_cin  = 1'($urandom);
            if (issue_ready) acc++;
            tick();
        end
        issue_valid = 1'b0;
        n_vec++;
        if (acc != 20) begin
            n_err++; $display("FAIL b2b_accepts got=%0d required=20", acc);
        end
        for (int i = 0; i < 4; i++) tick();
        res_ready = 1'b0;
        n_vec++;
        if (res_valid !== 1'b0 || sb.size() != 0) begin
            n_err++; $display("FAIL b2b_drain v=%b left=%0d required 0/0", res_valid, sb.size());
        end
    endtask

    task automatic test_flush();
        res_ready   = 1'b0;
        issue_valid = 1'b1;
        issue_hi    = 1'b0;
        nxt_s = 64'h11; nxt_c = 64'h0; nxt_cin = 1'b0;
        tick();
        nxt_s = 64'h22;
        tick();
        issue_valid = 1'b0;
        flush = 1'b1;
        #1;
        n_vec++;
        if (issue_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_ready got=%b required=0", issue_ready);
        end
        tick();
        flush = 1'b0;
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_valid got=%b required=0", res_valid);
        end
        do_issue(64'h7, 64'h0, 1'b0, 1'b0);
        tick();
        n_vec++;
        if (res_valid !== 1'b1 || res_full !== 64'h7) begin
            n_err++; $display("FAIL flush_new v=%b full=%h required 1/7", res_valid, res_full);
        end
        res_ready = 1'b1;
        tick();
        tick();
        res_ready = 1'b0;
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_only_one got=%b required=0", res_valid);
        end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        do_issue(64'hAAAA, 64'h1, 1'b0, 1'b0);
        do_issue(64'hBBBB, 64'h2, 1'b1, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        n_vec++;
        if (res_valid !== 1'b0 || res_full !== 64'd0 || res_data !== 32'd0) begin
            n_err++;
            $display("FAIL mid_rst v=%b full=%h data=%h required 0/0/0", res_valid, res_full, res_data);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (issue_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_rst_ready got=%b required=1", issue_ready);
        end
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        res_ready = 1'b0;
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_stale got=%b required=0", res_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_hi_select();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
